// File: rtl/tm_pkg.sv
// Shared types and constants for the programmable 2-symbol Turing machine.
package tm_pkg;

    localparam int unsigned DISP_W    = 11;
    localparam int unsigned MOVE_R    = 0;
    localparam int unsigned MOVE_L    = 1;
    localparam int unsigned MOVE_HALT = 2;

    typedef enum logic [3:0] {
        LOAD_TABLE,
        LOAD_HEAD,
        LOAD_TAPE,
        INIT_READ,
        WAIT,
        WRITE,
        MOVE,
        READ,
        HALT
    } tm_state_t;

    typedef enum logic [2:0] {
        DISP_HOLD,
        DISP_SET_LSB,
        DISP_LOAD_BIT,
        DISP_SHL,
        DISP_SHR
    } disp_op_t;

    // Table word holding the write bit for machine state s (1-based) reading symbol b.
    function automatic int unsigned table_base(int unsigned s, logic b);
        return 32'd1 + 32'd3 * (32'd2 * (s - 32'd1) + 32'(b));
    endfunction

endpackage

// File: rtl/tm_if.sv
// User-facing signal bundle of the Turing machine: load/step controls, display and debug taps.
interface tm_if
    import tm_pkg::*;
#(
    parameter int unsigned WIDTH = 6
);
    logic [WIDTH-1:0]  input_data;
    logic              Next;
    logic              Done;
    logic [DISP_W-1:0] display_out;
    logic              Compute_done;
    logic [3:0]        currState;
    logic              display_in;
    logic              tape_reg_out;
    logic              data_reg_out;
    logic [WIDTH-1:0]  next_state_out;
    logic [WIDTH-1:0]  tape_addr_out;

    modport master (
        output input_data, Next, Done,
        input  display_out, Compute_done, currState, display_in,
               tape_reg_out, data_reg_out, next_state_out, tape_addr_out
    );

    modport slave (
        input  input_data, Next, Done,
        output display_out, Compute_done, currState, display_in,
               tape_reg_out, data_reg_out, next_state_out, tape_addr_out
    );
endinterface

// File: rtl/tm_display_window.sv
// Tape window shift register; bit 0 mirrors the cell under the head.
module tm_display_window
    import tm_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  disp_op_t          op,
    input  logic              bit_in,
    output logic [DISP_W-1:0] window
);
    always_ff @(posedge clock) begin
        if (reset) begin
            window <= '0;
        end else begin
            case (op)
                DISP_SET_LSB:  window[0] <= bit_in;
                DISP_LOAD_BIT: window    <= {{(DISP_W-1){1'b0}}, bit_in};
                DISP_SHL:      window    <= {window[DISP_W-2:0], 1'b0};
                DISP_SHR:      window    <= {1'b0, window[DISP_W-1:1]};
                default:       ;
            endcase
        end
    end
endmodule

// File: rtl/turing_machine.sv
// Button-driven 2-symbol Turing machine: load table, head and tape, then one step per Next press.
module turing_machine
    import tm_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 64
) (
    input  logic clock,
    input  logic reset,
    tm_if.slave  bus
);
    localparam logic [WIDTH-1:0] MV_R    = WIDTH'(MOVE_R);
    localparam logic [WIDTH-1:0] MV_L    = WIDTH'(MOVE_L);
    localparam logic [WIDTH-1:0] MV_HALT = WIDTH'(MOVE_HALT);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(DEPTH - 1);

    tm_state_t         state, state_nxt;
    logic              next_q, done_q, next_act, done_edge;
    logic [WIDTH-1:0]  tbl_mem [DEPTH];
    logic [WIDTH-1:0]  tbl_ptr, tape_ptr, head, mstate, move_reg, next_reg;
    logic [DEPTH-1:0]  tape;
    logic              write_bit, data_bit, head_bit;
    int unsigned       tbl_base;
    logic [WIDTH-1:0]  idx_write, idx_move, idx_next;
    logic              tbl_we, tape_ld, head_ld, step_latch, tape_wr;
    logic              head_r, head_l, mstate_init, mstate_ld;
    disp_op_t          disp_op;
    logic              disp_bit;
    logic [DISP_W-1:0] display;

    function automatic logic [WIDTH-1:0] inc_wrap(logic [WIDTH-1:0] p);
        return (p == LAST) ? '0 : p + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] dec_wrap(logic [WIDTH-1:0] p);
        return (p == '0) ? LAST : p - WIDTH'(1);
    endfunction

    // Done has priority: a coincident Next edge is dropped rather than acted on.
    assign done_edge = bus.Done & ~done_q;
    assign next_act  = bus.Next & ~next_q & ~done_edge;
    assign head_bit  = tape[head];

    always_comb begin
        tbl_base  = table_base(32'(mstate), head_bit);
        idx_write = WIDTH'(tbl_base % DEPTH);
        idx_move  = WIDTH'((tbl_base + 32'd1) % DEPTH);
        idx_next  = WIDTH'((tbl_base + 32'd2) % DEPTH);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= LOAD_TABLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        tbl_we      = 1'b0;
        tape_ld     = 1'b0;
        head_ld     = 1'b0;
        step_latch  = 1'b0;
        tape_wr     = 1'b0;
        head_r      = 1'b0;
        head_l      = 1'b0;
        mstate_init = 1'b0;
        mstate_ld   = 1'b0;
        disp_op     = DISP_HOLD;
        disp_bit    = 1'b0;
        case (state)
            LOAD_TABLE: begin
                if (done_edge)     state_nxt = LOAD_HEAD;
                else if (next_act) tbl_we    = 1'b1;
            end
            LOAD_HEAD: begin
                if (next_act) begin
                    head_ld   = 1'b1;
                    state_nxt = LOAD_TAPE;
                end
            end
            LOAD_TAPE: begin
                if (done_edge)     state_nxt = INIT_READ;
                else if (next_act) tape_ld   = 1'b1;
            end
            INIT_READ: begin
                disp_op     = DISP_LOAD_BIT;
                disp_bit    = head_bit;
                mstate_init = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (next_act) begin
                    step_latch = 1'b1;
                    state_nxt  = WRITE;
                end
            end
            WRITE: begin
                tape_wr   = 1'b1;
                disp_op   = DISP_SET_LSB;
                disp_bit  = write_bit;
                state_nxt = MOVE;
            end
            MOVE: begin
                mstate_ld = 1'b1;
                state_nxt = READ;
                if (move_reg >= MV_HALT) begin
                    state_nxt = HALT;
                end else if (move_reg == MV_L) begin
                    head_l  = 1'b1;
                    disp_op = DISP_SHR;
                end else if (move_reg == MV_R) begin
                    head_r  = 1'b1;
                    disp_op = DISP_SHL;
                end
            end
            READ: begin
                disp_op   = DISP_SET_LSB;
                disp_bit  = head_bit;
                state_nxt = WAIT;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = LOAD_TABLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            next_q    <= 1'b0;
            done_q    <= 1'b0;
            tbl_ptr   <= '0;
            tape_ptr  <= '0;
            tape      <= '0;
            head      <= '0;
            mstate    <= WIDTH'(1);
            move_reg  <= '0;
            next_reg  <= '0;
            write_bit <= 1'b0;
            data_bit  <= 1'b0;
        end else begin
            next_q <= bus.Next;
            done_q <= bus.Done;
            if (tbl_we) tbl_ptr <= inc_wrap(tbl_ptr);
            if (head_ld) begin
                head     <= bus.input_data;
                tape_ptr <= bus.input_data;
            end
            if (tape_ld) begin
                tape[tape_ptr] <= bus.input_data[0];
                tape_ptr       <= inc_wrap(tape_ptr);
            end
            // The whole transition is captured at the Next sample so later phases never re-index the table.
            if (step_latch) begin
                data_bit  <= head_bit;
                write_bit <= tbl_mem[idx_write][0];
                move_reg  <= tbl_mem[idx_move];
                next_reg  <= tbl_mem[idx_next];
            end
            if (tape_wr)     tape[head] <= write_bit;
            if (head_r)      head       <= inc_wrap(head);
            if (head_l)      head       <= dec_wrap(head);
            if (mstate_init) mstate     <= WIDTH'(1);
            if (mstate_ld)   mstate     <= next_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (tbl_we) tbl_mem[tbl_ptr] <= bus.input_data;
    end

    tm_display_window u_window (
        .clock  (clock),
        .reset  (reset),
        .op     (disp_op),
        .bit_in (disp_bit),
        .window (display)
    );

    assign bus.display_out    = display;
    assign bus.Compute_done   = (state == HALT);
    assign bus.currState      = state;
    assign bus.display_in     = head_bit;
    assign bus.tape_reg_out   = write_bit;
    assign bus.data_reg_out   = data_bit;
    assign bus.next_state_out = mstate;
    assign bus.tape_addr_out  = head;
endmodule

// File: tb/tb_turing_machine.sv
// Scoreboard bench for turing_machine: unary-add program, head wrap program and mid-step reset.
module tb_turing_machine;
    import tm_pkg::*;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned DEPTH = 64;

    typedef struct packed {
        logic [31:0]       due;
        logic [1:0]        kind;
        logic [DISP_W-1:0] disp;
        logic              cdone;
        logic [5:0]        addr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    string       sb_name[$];
    exp_t        cur;
    string       cur_name;

    int unsigned prog_a [19] = '{3, 1, 0, 2, 1, 0, 1, 0, 1, 3, 1, 0, 2, 0, 2, 3, 0, 2, 3};
    int unsigned tape_a [9]  = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
    logic [10:0] disp_a [10] = '{11'b00000000011, 11'b00000000111, 11'b00000001111,
                                 11'b00000011110, 11'b00000111111, 11'b00001111111,
                                 11'b00011111111, 11'b00111111110, 11'b00011111111,
                                 11'b00011111110};
    int unsigned addr_a [10] = '{33, 34, 35, 36, 37, 38, 39, 40, 39, 39};
    int unsigned prog_b [7]  = '{1, 0, 0, 1, 1, 1, 1};

    tm_if #(.WIDTH(WIDTH)) bus ();

    turing_machine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            cur      = sb.pop_front();
            cur_name = sb_name.pop_front();
            if (cur.due != cyc) begin
                chk({cur_name, "_late"}, cyc, cur.due);
            end else begin
                chk({cur_name, "_disp"}, 32'(bus.display_out), 32'(cur.disp));
                chk({cur_name, "_done"}, 32'(bus.Compute_done), 32'(cur.cdone));
                if (cur.kind != 2'd0)
                    chk({cur_name, "_addr"}, 32'(bus.tape_addr_out), 32'(cur.addr));
                if (cur.kind == 2'd2) begin
                    chk({cur_name, "_state"}, 32'(bus.currState), 32'(LOAD_TABLE));
                    chk({cur_name, "_dispin"}, 32'(bus.display_in), 32'd0);
                    chk({cur_name, "_tapereg"}, 32'(bus.tape_reg_out), 32'd0);
                    chk({cur_name, "_datareg"}, 32'(bus.data_reg_out), 32'd0);
                    chk({cur_name, "_mstate"}, 32'(bus.next_state_out), 32'd1);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_at(string name, int unsigned due, logic [1:0] kind,
                             logic [10:0] d, logic c, logic [5:0] a);
        exp_t e;
        e.due   = due;
        e.kind  = kind;
        e.disp  = d;
        e.cdone = c;
        e.addr  = a;
        sb.push_back(e);
        sb_name.push_back(name);
    endtask

    task automatic press_next(logic [5:0] v, int hold);
        bus.input_data = v;
        bus.Next       = 1'b1;
        tick(hold);
        bus.Next = 1'b0;
        tick(1);
    endtask

    task automatic press_done();
        bus.Done = 1'b1;
        tick(1);
        bus.Done = 1'b0;
        tick(1);
    endtask

    // Next rises at cycle k: write lands at k+2, halt at k+3, read-back at k+4.
    task automatic step(string name, logic [10:0] fin, logic fin_done, logic [5:0] fin_addr,
                        logic mid_en, logic [10:0] mid);
        int unsigned k;
        k = cyc;
        bus.Next = 1'b1;
        if (mid_en) expect_at({name, "_mid"}, k + 2, 2'd0, mid, 1'b0, '0);
        if (mid_en && fin_done) expect_at({name, "_halt"}, k + 3, 2'd0, fin, 1'b1, '0);
        expect_at(name, k + 4, 2'd1, fin, fin_done, fin_addr);
        tick(1);
        bus.Next = 1'b0;
        tick(5);
    endtask

    initial begin
        bus.input_data = '0;
        bus.Next       = 1'b0;
        bus.Done       = 1'b0;
        reset          = 1'b1;
        tick(3);
        reset = 1'b0;
        expect_at("reset", cyc + 1, 2'd2, '0, 1'b0, '0);
        tick(2);

        // Word 0 held for six cycles: a repeated store would misalign every triple.
        press_next(6'(prog_a[0]), 6);
        for (int i = 1; i < 19; i++) press_next(6'(prog_a[i]), 1);
        press_done();
        press_next(6'd32, 1);
        for (int i = 0; i < 9; i++) press_next(6'(tape_a[i]), 1);
        press_done();
        expect_at("init_a", cyc + 1, 2'd1, 11'b00000000001, 1'b0, 6'd32);
        tick(2);
        press_done();

        for (int i = 0; i < 10; i++)
            step($sformatf("step%0d", i + 1), disp_a[i], (i == 9), 6'(addr_a[i]),
                 (i == 4 || i == 9), (i == 4) ? 11'b00000011111 : 11'b00011111110);
        for (int i = 0; i < 4; i++)
            step($sformatf("halted%0d", i), 11'b00011111110, 1'b1, 6'd39, 1'b0, '0);

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        for (int i = 0; i < 7; i++) press_next(6'(prog_b[i]), 1);
        press_done();
        press_next(6'd0, 1);
        press_next(6'd1, 1);
        press_done();
        expect_at("init_b", cyc + 1, 2'd1, 11'b00000000001, 1'b0, 6'd0);
        tick(2);
        step("wrap_left", 11'b00000000000, 1'b0, 6'd63, 1'b0, '0);
        step("wrap_right", 11'b00000000001, 1'b0, 6'd0, 1'b0, '0);

        bus.Next = 1'b1;
        tick(1);
        bus.Next = 1'b0;
        tick(1);
        reset = 1'b1;
        expect_at("mid_reset", cyc + 1, 2'd2, '0, 1'b0, '0);
        tick(2);
        reset = 1'b0;
        expect_at("post_reset", cyc + 1, 2'd2, '0, 1'b0, '0);
        tick(4);

        while (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: not sampled, required at cycle %0d", sb_name.pop_front(), sb.pop_front().due);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, time limit reached");
        $fatal(1);
    end
endmodule
